// File: rtl/lsu_mem_stage_pkg.sv
// Shared core pipeline types (EX/MEM, MEM/WB) and load/store funct3 encodings.
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_LB_SB = 3'b000;
  localparam logic [2:0] F3_LH_SH = 3'b001;
  localparam logic [2:0] F3_LW_SW = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_LHU   = 3'b101;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memwrite;
    logic        memread;
    logic [2:0]  funct3;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] readdata;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
    logic        regwrite;
    logic [1:0]  resultsrc;
  } mem_wb_t;

  // Load fields parked while the RAM read and wait states elapse.
  typedef struct packed {
    logic [31:0] aluresult;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [2:0]  funct3;
    logic        mis;
  } lsu_pend_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  function automatic acc_size_e acc_size(input logic [2:0] f3);
    case (f3)
      F3_LB_SB, F3_LBU: return SZ_BYTE;
      F3_LH_SH, F3_LHU: return SZ_HALF;
      F3_LW_SW:         return SZ_WORD;
      default:          return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bram.sv
// Byte-enabled single-port word RAM with one-cycle registered read; contents survive reset.
module lsu_bram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (en_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: stores/non-memory ops complete next cycle, loads stall for 1+WAIT_STATES cycles.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned halfword/word accesses).
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int WAIT_STATES = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  ex_mem_t in,
  output logic    stall,
  output logic    out_valid,
  output mem_wb_t out,
  output logic    misalign
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  lsu_pend_t   pend_q, pend_d;
  mem_wb_t     out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        misalign_q, misalign_d;

  logic        busy, accept, is_load, is_store, raw_mis, mis;
  acc_size_e   size;
  logic [3:0]  be, ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_en;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (acc_size(f3))
      SZ_BYTE: return (f3 == F3_LBU) ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return (f3 == F3_LHU) ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign busy     = (state_q == S_WAIT);
  assign accept   = in_valid && !busy && !rst;
  assign is_store = in.memwrite;
  assign is_load  = in.memread && !in.memwrite;
  assign size     = acc_size(in.funct3);

  always_comb begin
    raw_mis = 1'b0;
    case (size)
      SZ_HALF: raw_mis = in.aluresult[0];
      SZ_WORD: raw_mis = |in.aluresult[1:0];
      default: raw_mis = 1'b0;
    endcase
  end

  assign mis = TRAP_EN && (is_load || is_store) && raw_mis;

  // Lane selection ignores the low address bits that lie below the access size.
  always_comb begin
    be        = 4'b1111;
    ram_wdata = in.writedata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << in.aluresult[1:0];
        ram_wdata = {4{in.writedata[7:0]}};
      end
      SZ_HALF: begin
        be        = in.aluresult[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{in.writedata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        ram_wdata = in.writedata;
      end
    endcase
  end

  assign ram_we = (accept && is_store && !mis) ? be : 4'b0000;
  assign ram_en = accept && is_load;

  lsu_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (in.aluresult[ADDR_W+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    out_d       = '0;
    out_valid_d = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept && is_load) begin
          state_d          = S_WAIT;
          cnt_d            = WAIT_CNT;
          pend_d.aluresult = in.aluresult;
          pend_d.rd        = in.rd;
          pend_d.pcplus4   = in.pcplus4;
          pend_d.regwrite  = in.regwrite;
          pend_d.resultsrc = in.resultsrc;
          pend_d.funct3    = in.funct3;
          pend_d.mis       = mis;
        end else if (accept) begin
          out_valid_d     = 1'b1;
          misalign_d      = mis;
          out_d.aluresult = in.aluresult;
          out_d.rd        = in.rd;
          out_d.pcplus4   = in.pcplus4;
          out_d.regwrite  = in.regwrite;
          out_d.resultsrc = in.resultsrc;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d         = S_RESP;
          out_valid_d     = 1'b1;
          misalign_d      = pend_q.mis;
          out_d.aluresult = pend_q.aluresult;
          out_d.readdata  = pend_q.mis ? 32'h0
                          : load_extract(ram_rdata, pend_q.funct3, pend_q.aluresult[1:0]);
          out_d.rd        = pend_q.rd;
          out_d.pcplus4   = pend_q.pcplus4;
          out_d.regwrite  = pend_q.regwrite;
          out_d.resultsrc = pend_q.resultsrc;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Completion register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      misalign_q  <= misalign_d;
    end
    pend_q <= pend_d;
  end

  assign stall     = busy && !rst;
  assign out_valid = out_valid_q && !rst;
  assign misalign  = misalign_q && !rst;
  assign out       = rst ? '0 : out_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed scoreboard bench for lsu_mem_stage: one instance with WAIT_STATES=0, one with 3.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  typedef struct packed {
    mem_wb_t out;
    logic    mis;
  } exp_t;

  logic    clk, rst;
  logic    v0, v3, stall0, stall3, ov0, ov3, mis0, mis3;
  ex_mem_t i0, i3;
  mem_wb_t out0, out3;
  exp_t    q0[$], q3[$];
  int      checks = 0;
  int      errors = 0;

  lsu_mem_stage #(.ADDR_W(13), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in(i0),
    .stall(stall0), .out_valid(ov0), .out(out0), .misalign(mis0));

  lsu_mem_stage #(.ADDR_W(13), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in(i3),
    .stall(stall3), .out_valid(ov3), .out(out3), .misalign(mis3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_mem_t mk(input logic rd_, input logic wr_, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    ex_mem_t op;
    op.aluresult = a;
    op.writedata = wd;
    op.rd        = a[6:2] ^ 5'h15;
    op.pcplus4   = 32'h1000 + a;
    op.regwrite  = ~wr_;
    op.resultsrc = {1'b0, rd_};
    op.memwrite  = wr_;
    op.memread   = rd_;
    op.funct3    = f3;
    return op;
  endfunction

  function automatic exp_t mkexp(input ex_mem_t op, input logic [31:0] rdata, input logic m);
    exp_t e;
    e.out.aluresult = op.aluresult;
    e.out.readdata  = rdata;
    e.out.rd        = op.rd;
    e.out.pcplus4   = op.pcplus4;
    e.out.regwrite  = op.regwrite;
    e.out.resultsrc = op.resultsrc;
    e.mis           = m;
    return e;
  endfunction

  task automatic drive(input int sel, input logic v, input ex_mem_t op);
    if (sel == 0) begin v0 = v; i0 = op; end
    else begin v3 = v; i3 = op; end
  endtask

  task automatic push(input int sel, input ex_mem_t op, input logic [31:0] rdata, input logic m);
    if (sel == 0) q0.push_back(mkexp(op, rdata, m));
    else q3.push_back(mkexp(op, rdata, m));
  endtask

  // One op on the chosen instance; checks stall profile and completion latency.
  task automatic run(input int sel, input ex_mem_t op, input logic [31:0] rdata, input logic m);
    int lat, ws;
    logic ld, ov, st;
    ws  = (sel == 0) ? 0 : 3;
    ld  = op.memread & ~op.memwrite;
    lat = 0;
    @(posedge clk); #1;
    drive(sel, 1'b1, op);
    push(sel, op, rdata, m);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) drive(sel, 1'b0, op);
      @(negedge clk);
      ov = (sel == 0) ? ov0 : ov3;
      st = (sel == 0) ? stall0 : stall3;
      if (ov) begin
        lat = k;
        chk("stall_at_done", 128'(st), 128'(0));
      end else begin
        chk("stall_profile", 128'(st), 128'(ld && k <= ws + 1));
      end
    end
    chk("latency", 128'(lat), 128'(ld ? ws + 2 : 1));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ov0) begin
      chk("sb0_pending", 128'(q0.size() != 0), 128'(1));
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("out0", 128'(out0), 128'(e.out));
        chk("mis0", 128'(mis0), 128'(e.mis));
      end
    end else begin
      chk("mis0_idle", 128'(mis0), 128'(0));
    end
    if (ov3) begin
      chk("sb3_pending", 128'(q3.size() != 0), 128'(1));
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("out3", 128'(out3), 128'(e.out));
        chk("mis3", 128'(mis3), 128'(e.mis));
      end
    end
  end

  initial begin
    ex_mem_t op;
    rst = 1'b1; v0 = 1'b0; v3 = 1'b0; i0 = '0; i3 = '0;

    // Reset: a store presented during reset must vanish and all outputs read zero.
    repeat (2) begin
      @(posedge clk); #1;
      v0 = 1'b1; i0 = mk(1'b0, 1'b1, F3_LW_SW, 32'h30, 32'h1);
      @(negedge clk);
      chk("rst_ov0", 128'(ov0), 128'(0));
      chk("rst_stall0", 128'(stall0), 128'(0));
      chk("rst_mis0", 128'(mis0), 128'(0));
      chk("rst_out0", 128'(out0), 128'(0));
      chk("rst_ov3", 128'(ov3), 128'(0));
    end
    @(posedge clk); #1; rst = 1'b0; v0 = 1'b0;
    @(negedge clk);
    chk("rst_store_no_done", 128'(ov0), 128'(0));

    // Word store then load, byte/halfword variants
    run(0, mk(1'b0, 1'b1, F3_LW_SW, 32'h10, 32'hDEADBEEF), 32'h0, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h10, 32'h0), 32'hDEADBEEF, 1'b0);
    run(0, mk(1'b0, 1'b1, F3_LB_SB, 32'h13, 32'h00000080), 32'h0, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LB_SB, 32'h13, 32'h0), 32'hFFFFFF80, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LBU, 32'h13, 32'h0), 32'h00000080, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h10, 32'h0), 32'h80ADBEEF, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LH_SH, 32'h12, 32'h0), 32'hFFFF80AD, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LHU, 32'h10, 32'h0), 32'h0000BEEF, 1'b0);
    run(0, mk(1'b0, 1'b1, F3_LH_SH, 32'h16, 32'h00001234), 32'h0, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LHU, 32'h16, 32'h0), 32'h00001234, 1'b0);

    // Address aliasing: 0x8010 maps onto word 0x10
    run(0, mk(1'b0, 1'b1, F3_LW_SW, 32'h8010, 32'hCAFEF00D), 32'h0, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h10, 32'h0), 32'hCAFEF00D, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h8010, 32'h0), 32'hCAFEF00D, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    run(0, mk(1'b0, 1'b1, F3_LW_SW, 32'h11, 32'h99999999), 32'h0, 1'b1);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h10, 32'h0), 32'hCAFEF00D, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h11, 32'h0), 32'h0, 1'b1);
    run(0, mk(1'b1, 1'b0, F3_LH_SH, 32'h11, 32'h0), 32'h0, 1'b1);
`else
    run(0, mk(1'b0, 1'b1, F3_LW_SW, 32'h11, 32'h99999999), 32'h0, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h10, 32'h0), 32'h99999999, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h11, 32'h0), 32'h99999999, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LH_SH, 32'h11, 32'h0), 32'hFFFF9999, 1'b0);
`endif

    // Non-memory op and memread+memwrite treated as a store
    run(0, mk(1'b0, 1'b0, F3_LW_SW, 32'h00000011, 32'h0), 32'h0, 1'b0);
    run(0, mk(1'b1, 1'b1, F3_LW_SW, 32'h20, 32'h0BADF00D), 32'h0, 1'b0);
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h20, 32'h0), 32'h0BADF00D, 1'b0);

    // Store coinciding with reset is dropped; memory keeps its contents
    @(posedge clk); #1;
    rst = 1'b1; v0 = 1'b1; i0 = mk(1'b0, 1'b1, F3_LW_SW, 32'h20, 32'h55555555);
    @(negedge clk);
    chk("rst2_out0", 128'(out0), 128'(0));
    @(posedge clk); #1; rst = 1'b0; v0 = 1'b0;
    @(negedge clk);
    chk("rst2_no_done", 128'(ov0), 128'(0));
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h20, 32'h0), 32'h0BADF00D, 1'b0);

    // Reset at T+1 of a load aborts it
    @(posedge clk); #1;
    v0 = 1'b1; i0 = mk(1'b1, 1'b0, F3_LW_SW, 32'h10, 32'h0);
    @(negedge clk);
    @(posedge clk); #1; v0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_stall", 128'(stall0), 128'(0));
    chk("abort_rst_ov", 128'(ov0), 128'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("abort_t2_stall", 128'(stall0), 128'(0));
    chk("abort_t2_ov", 128'(ov0), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_t3_ov", 128'(ov0), 128'(0));
    run(0, mk(1'b1, 1'b0, F3_LW_SW, 32'h20, 32'h0), 32'h0BADF00D, 1'b0);

    // WAIT_STATES=3: load, second op held through the stall
    run(1, mk(1'b0, 1'b1, F3_LW_SW, 32'h40, 32'h0A0B0C0D), 32'h0, 1'b0);
    @(posedge clk); #1;
    op = mk(1'b1, 1'b0, F3_LW_SW, 32'h40, 32'h0);
    v3 = 1'b1; i3 = op; push(1, op, 32'h0A0B0C0D, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    op = mk(1'b0, 1'b1, F3_LW_SW, 32'h44, 32'h00000077);
    i3 = op; push(1, op, 32'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("ws3_stall", 128'(stall3), 128'(1));
      chk("ws3_ov_early", 128'(ov3), 128'(0));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("ws3_t5_ov", 128'(ov3), 128'(1));
    chk("ws3_t5_stall", 128'(stall3), 128'(0));
    @(posedge clk); #1; v3 = 1'b0;
    @(negedge clk);
    chk("ws3_t6_ov", 128'(ov3), 128'(1));
    chk("ws3_t6_stall", 128'(stall3), 128'(0));
    run(1, mk(1'b1, 1'b0, F3_LW_SW, 32'h44, 32'h0), 32'h00000077, 1'b0);
    run(1, mk(1'b1, 1'b0, F3_LB_SB, 32'h41, 32'h0), 32'h0000000C, 1'b0);
    run(1, mk(1'b0, 1'b0, F3_LB_SB, 32'h5, 32'h0), 32'h0, 1'b0);

    repeat (3) begin @(posedge clk); #1; @(negedge clk); end
    chk("q0_drained", 128'(q0.size()), 128'(0));
    chk("q3_drained", 128'(q3.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
